// File: rtl/output_layer_argmax.sv
// output_layer_argmax: steps the output neuron over every class, samples each score and returns the argmax
// Optional macro ARGMAX_REJECT_EN: a winning score below REJECT_THRESH is reported as class NUM_CLASSES.
module output_layer_argmax #(
  parameter int NUM_CLASSES = 4,
  parameter int DW = 16,
  parameter int SETTLE = 1
`ifdef ARGMAX_REJECT_EN
  ,
  parameter logic [DW-1:0] REJECT_THRESH = DW'(16'h0800)
`endif
) (
  input  logic            clk,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [8*DW-1:0] h_vec_i,
  output logic [8*DW-1:0] h_lat_o,
  output logic [2:0]      nn_addr_o,
  input  logic [DW-1:0]   nn_score_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      class_id_o,
  output logic [DW-1:0]   max_score_o,
  output logic            busy_o
);
  localparam logic [1:0] IDLE = 2'd0, SETL = 2'd1, SAMP = 2'd2, DONE = 2'd3;
  localparam logic [1:0] FIRST = (SETTLE == 0) ? SAMP : SETL;
  logic [1:0]      state_q, state_d;
  logic [2:0]      addr_q, addr_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [DW-1:0]   best_q, best_d;
  logic [8*DW-1:0] h_q, h_d;
  logic            take, last;
  logic [DW-1:0]   nbest;
  logic [2:0]      nidx, fidx;
  assign take  = (addr_q == 3'd0) || ($signed(nn_score_i) > $signed(best_q));
  assign last  = addr_q == 3'(NUM_CLASSES - 1);
  assign nbest = take ? nn_score_i : best_q;
  assign nidx  = take ? addr_q : idx_q;
`ifdef ARGMAX_REJECT_EN
  assign fidx  = (last && $signed(nbest) < $signed(REJECT_THRESH)) ? 3'(NUM_CLASSES) : nidx;
`else
  assign fidx  = nidx;
`endif
  assign in_ready_o  = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign out_valid_o = state_q == DONE;
  assign h_lat_o     = h_q;
  assign nn_addr_o   = addr_q;
  assign class_id_o  = idx_q;
  assign max_score_o = best_q;
  // scan sequencing: accept, settle, sample each class, hold result until taken
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    best_d  = best_q;
    h_d     = h_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        h_d     = h_vec_i;
        addr_d  = 3'd0;
        cnt_d   = 3'd0;
        state_d = FIRST;
      end
      SETL: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'(SETTLE - 1)) ? SAMP : SETL;
      end
      SAMP: begin
        best_d  = nbest;
        idx_d   = fidx;
        addr_d  = last ? addr_q : addr_q + 3'd1;
        cnt_d   = 3'd0;
        state_d = last ? DONE : FIRST;
      end
      default: state_d = out_ready_i ? IDLE : DONE;
    endcase
  end
  // state registers with synchronous active-low reset discarding any partial scan
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      h_q     <= h_d;
    end
  end
endmodule

// File: tb/tb_output_layer_argmax.sv
// tb_output_layer_argmax: randomized and directed checks of the argmax scanner against a table-driven neuron model
module tb_output_layer_argmax;
`ifdef ARGMAX_REJECT_EN
  localparam int NC2 = 7;
`else
  localparam int NC2 = 8;
`endif
  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, in_valid2 = 0, out_ready = 0, out_ready2 = 0;
  logic [127:0] h_vec = '0;
  logic         in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
  logic [127:0] h_lat, h_lat2;
  logic [2:0]   nn_addr, class_id, nn_addr2, class_id2;
  logic [15:0]  nn_score, max_score, nn_score2, max_score2;
  logic [15:0]  tbl [8];
  int           tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign nn_score  = tbl[nn_addr];
  assign nn_score2 = tbl[nn_addr2];

  output_layer_argmax #(.NUM_CLASSES(4), .DW(16), .SETTLE(1)) dut (
    .clk(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .h_vec_i(h_vec), .h_lat_o(h_lat), .nn_addr_o(nn_addr), .nn_score_i(nn_score),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .class_id_o(class_id),
    .max_score_o(max_score), .busy_o(busy));

  output_layer_argmax #(.NUM_CLASSES(NC2), .DW(16), .SETTLE(0)) dut2 (
    .clk(clk), .rst_n_i(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .h_vec_i(h_vec), .h_lat_o(h_lat2), .nn_addr_o(nn_addr2), .nn_score_i(nn_score2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .class_id_o(class_id2),
    .max_score_o(max_score2), .busy_o(busy2));

  function automatic void model(input int n, output logic [15:0] b, output logic [2:0] k);
    b = tbl[0];
    k = 3'd0;
    for (int i = 1; i < n; i++)
      if ($signed(tbl[i]) > $signed(b)) begin
        b = tbl[i];
        k = 3'(i);
      end
`ifdef ARGMAX_REJECT_EN
    if ($signed(b) < $signed(16'h0800)) k = 3'(n);
`endif
  endfunction

  task automatic test_reset();
    tests++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || nn_addr !== 0 || class_id !== 0 || max_score !== 0 || h_lat !== 0) begin
      fails++;
      $display("FAIL reset: rdy=%0b ov=%0b busy=%0b addr=%0d cls=%0d max=%h hlat_nz=%0b required 1 0 0 0 0 0000 0", in_ready, out_valid, busy, nn_addr, class_id, max_score, |h_lat);
    end
    tests++;
    if (in_ready2 !== 1 || out_valid2 !== 0 || busy2 !== 0 || nn_addr2 !== 0 || class_id2 !== 0 || max_score2 !== 0) begin
      fails++;
      $display("FAIL reset2: rdy=%0b ov=%0b busy=%0b addr=%0d cls=%0d max=%h", in_ready2, out_valid2, busy2, nn_addr2, class_id2, max_score2);
    end
  endtask

  task automatic scan1(input string nm);
    logic [15:0]  eb;
    logic [2:0]   ek;
    logic [127:0] hv;
    int           lat;
    model(4, eb, ek);
    hv = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1;
    h_vec = hv;
    @(negedge clk);
    in_valid = 0;
    h_vec = ~hv;
    tests++;
    if (in_ready !== 0 || busy !== 1) begin
      fails++;
      $display("FAIL %s busy: in_ready=%0b busy=%0b required 0 1", nm, in_ready, busy);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != 8) begin
      fails++;
      $display("FAIL %s latency: got %0d required 8", nm, lat);
    end
    tests++;
    if (class_id !== ek || max_score !== eb) begin
      fails++;
      $display("FAIL %s result: class=%0d max=%h required class=%0d max=%h", nm, class_id, max_score, ek, eb);
    end
    tests++;
    if (h_lat !== hv || nn_addr !== 3'd3) begin
      fails++;
      $display("FAIL %s hold: h_lat_ok=%0b addr=%0d required 1 3", nm, h_lat === hv, nn_addr);
    end
  endtask

  task automatic release1(input string nm);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    tests++;
    if (out_valid !== 0 || in_ready !== 1) begin
      fails++;
      $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    tbl = '{16'h0100, 16'h0400, 16'h0200, 16'h0300, 0, 0, 0, 0};
    scan1("basic");
    release1("basic");
    tbl = '{16'h0300, 16'h0300, 0, 0, 0, 0, 0, 0};
    scan1("tie");
    release1("tie");
    tbl = '{0, 0, 0, 16'h0001, 0, 0, 0, 0};
    scan1("last");
    release1("last");
    tbl = '{0, 0, 0, 0, 0, 0, 0, 0};
    scan1("zero");
    release1("zero");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++)
        tbl[i] = t[0] ? 16'($urandom_range(0, 3) * 16'h0400) : 16'($urandom);
      scan1("random");
      release1("random");
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]   c;
    logic [15:0]  m;
    logic [127:0] hl;
    for (int i = 0; i < 8; i++) tbl[i] = 16'($urandom_range(0, 16'h7fff));
    scan1("bp");
    c = class_id;
    m = max_score;
    hl = h_lat;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      h_vec = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      tests++;
      if (out_valid !== 1 || class_id !== c || max_score !== m || in_ready !== 0 || h_lat !== hl) begin
        fails++;
        $display("FAIL bp hold: ov=%0b cls=%0d max=%h rdy=%0b hlat_ok=%0b required 1 %0d %h 0 1", out_valid, class_id, max_score, in_ready, h_lat === hl, c, m);
      end
    end
    in_valid = 0;
    release1("bp");
    scan1("bp_next");
    release1("bp_next");
  endtask

  task automatic test_reset_midscan();
    for (int i = 0; i < 8; i++) tbl[i] = 16'($urandom);
    in_valid = 1;
    h_vec = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1;
    scan1("post_rst");
    release1("post_rst");
  endtask

  task automatic test_settle0();
    logic [15:0] eb;
    logic [2:0]  ek;
    int          lat;
    for (int i = 0; i < 8; i++) tbl[i] = 16'(i * 16'h0100);
    model(NC2, eb, ek);
    in_valid2 = 1;
    h_vec = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid2 = 0;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != NC2) begin
      fails++;
      $display("FAIL settle0 latency: got %0d required %0d", lat, NC2);
    end
    tests++;
    if (class_id2 !== ek || max_score2 !== eb) begin
      fails++;
      $display("FAIL settle0 result: class=%0d max=%h required class=%0d max=%h", class_id2, max_score2, ek, eb);
    end
    out_ready2 = 1;
    @(negedge clk);
    out_ready2 = 0;
    tests++;
    if (out_valid2 !== 0 || in_ready2 !== 1) begin
      fails++;
      $display("FAIL settle0 release: out_valid=%0b in_ready=%0b required 0 1", out_valid2, in_ready2);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midscan();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
